// File: rtl/magia_fixture_pkg.sv
// ---------------------------------------------------------------------------
// magia_fixture_pkg : shared types and constants for the MAGIA tile fixture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package magia_fixture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fixture_state_e;

  localparam logic [31:0] EOC_ADDR_DEFAULT = 32'h1A10_0000;
  localparam logic [31:0] FILL_WORD        = 32'hDEAD_BEEF;

endpackage

`default_nettype wire

// File: rtl/magia_fixture_mem.sv
// ---------------------------------------------------------------------------
// magia_fixture_mem : word memory, one byte-enabled access port plus preload
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module magia_fixture_mem
  import magia_fixture_pkg::*;
#(
  parameter int unsigned WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [29:0] idx_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        pl_we_i,
  input  logic [31:0] pl_idx_i,
  input  logic [31:0] pl_wdata_i
);

  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;
  logic        hit;
  logic        pl_hit;

  assign hit    = ({2'b00, idx_i} < WORDS);
  assign pl_hit = (pl_idx_i < WORDS);

  // Contents are deliberately not reset so preloaded images survive rst_i.
  always_ff @(posedge clk_i) begin
    if (pl_we_i && pl_hit) begin
      mem_q[pl_idx_i[AW-1:0]] <= pl_wdata_i;
    end
    if (req_i && we_i && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i[AW-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (req_i) begin
      rdata_q <= hit ? mem_q[idx_i[AW-1:0]] : FILL_WORD;
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/magia_tile_fixture.sv
// ---------------------------------------------------------------------------
// magia_tile_fixture : boot/run control, instr+data memories and EOC register.
// Optional MAGIA_FIXTURE_STDOUT_EN adds a character port at EOC_ADDR+4.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module magia_tile_fixture
  import magia_fixture_pkg::*;
#(
  parameter int unsigned INST_WORDS = 1024,
  parameter int unsigned DATA_WORDS = 1024,
  parameter logic [31:0] EOC_ADDR   = EOC_ADDR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pl_we_i,
  input  logic        pl_sel_i,
  input  logic [31:0] pl_addr_i,
  input  logic [31:0] pl_wdata_i,
  input  logic [31:0] boot_addr_i,
  input  logic        init_i,
  input  logic        run_i,
  output logic        reset_done_o,
  output logic        fetch_en_o,
  output logic [31:0] boot_addr_o,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        eoc_o,
`ifdef MAGIA_FIXTURE_STDOUT_EN
  output logic [31:0] exit_code_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o
`else
  output logic [31:0] exit_code_o
`endif
);

  localparam logic [31:0] STDOUT_ADDR = EOC_ADDR + 32'd4;

  fixture_state_e state_q, state_d;
  logic [31:0]    boot_q, boot_d;
  logic [31:0]    exit_q, exit_d;
  logic           eoc_q, eoc_d;
  logic           reset_done_q;
  logic           instr_rvalid_q;
  logic           data_rvalid_q;
  logic           rd_eoc_q, rd_eoc_d;
  logic           rd_stdout_q, rd_stdout_d;

  logic           is_eoc;
  logic           is_stdout;
  logic           pl_allowed;
  logic           dmem_req;
  logic [31:0]    imem_rdata;
  logic [31:0]    dmem_rdata;
  logic           unused_addr_bits;

  assign is_eoc     = (data_addr_i == EOC_ADDR);
  assign is_stdout  = (data_addr_i == STDOUT_ADDR);
  assign pl_allowed = pl_we_i && ((state_q == ST_IDLE) || (state_q == ST_INIT));
  // Register-mapped addresses never reach the data memory.
  assign dmem_req   = data_req_i && !is_eoc && !is_stdout;
  assign unused_addr_bits = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    exit_d      = exit_q;
    eoc_d       = eoc_q;
    rd_eoc_d    = data_req_i && !data_we_i && is_eoc;
    rd_stdout_d = data_req_i && !data_we_i && is_stdout;
    fetch_en_o  = (state_q == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        if (init_i) begin
          state_d = ST_INIT;
          boot_d  = boot_addr_i;
        end
      end
      ST_INIT: begin
        if (run_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (data_req_i && data_we_i && is_eoc) begin
          state_d = ST_DONE;
          exit_d  = data_wdata_i;
          eoc_d   = 1'b1;
        end
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      boot_q         <= '0;
      exit_q         <= '0;
      eoc_q          <= 1'b0;
      reset_done_q   <= 1'b0;
      instr_rvalid_q <= 1'b0;
      data_rvalid_q  <= 1'b0;
      rd_eoc_q       <= 1'b0;
      rd_stdout_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      boot_q         <= boot_d;
      exit_q         <= exit_d;
      eoc_q          <= eoc_d;
      reset_done_q   <= 1'b1;
      instr_rvalid_q <= instr_req_i;
      data_rvalid_q  <= data_req_i;
      rd_eoc_q       <= rd_eoc_d;
      rd_stdout_q    <= rd_stdout_d;
    end
  end

`ifdef MAGIA_FIXTURE_STDOUT_EN
  logic       stdout_valid_q;
  logic [7:0] stdout_char_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stdout_valid_q <= 1'b0;
      stdout_char_q  <= '0;
    end else begin
      stdout_valid_q <= data_req_i && data_we_i && is_stdout;
      stdout_char_q  <= data_wdata_i[7:0];
    end
  end

  assign stdout_valid_o = stdout_valid_q;
  assign stdout_char_o  = stdout_char_q;
`endif

  magia_fixture_mem #(
    .WORDS (INST_WORDS)
  ) u_imem (
    .clk_i      (clk_i),
    .req_i      (instr_req_i),
    .we_i       (1'b0),
    .be_i       (4'b0000),
    .idx_i      (instr_addr_i[31:2]),
    .wdata_i    (32'h0),
    .rdata_o    (imem_rdata),
    .pl_we_i    (pl_allowed && !pl_sel_i),
    .pl_idx_i   (pl_addr_i),
    .pl_wdata_i (pl_wdata_i)
  );

  magia_fixture_mem #(
    .WORDS (DATA_WORDS)
  ) u_dmem (
    .clk_i      (clk_i),
    .req_i      (dmem_req),
    .we_i       (data_we_i),
    .be_i       (data_be_i),
    .idx_i      (data_addr_i[31:2]),
    .wdata_i    (data_wdata_i),
    .rdata_o    (dmem_rdata),
    .pl_we_i    (pl_allowed && pl_sel_i),
    .pl_idx_i   (pl_addr_i),
    .pl_wdata_i (pl_wdata_i)
  );

  assign reset_done_o   = reset_done_q;
  assign boot_addr_o    = boot_q;
  assign eoc_o          = eoc_q;
  assign exit_code_o    = exit_q;
  assign instr_gnt_o    = instr_req_i;
  assign data_gnt_o     = data_req_i;
  assign instr_rvalid_o = instr_rvalid_q;
  assign instr_rdata_o  = imem_rdata;
  assign data_rvalid_o  = data_rvalid_q;
  assign data_rdata_o   = rd_eoc_q    ? exit_q :
                          rd_stdout_q ? FILL_WORD : dmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_magia_tile_fixture.sv
// ---------------------------------------------------------------------------
// tb_magia_tile_fixture : directed vector bench for magia_tile_fixture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_magia_tile_fixture;

  localparam int unsigned IW  = 16;
  localparam int unsigned DW  = 16;
  localparam logic [31:0] EOC = 32'h1A10_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        pl_we_i = 1'b0, pl_sel_i = 1'b0;
  logic [31:0] pl_addr_i = '0, pl_wdata_i = '0, boot_addr_i = '0;
  logic        init_i = 1'b0, run_i = 1'b0;
  logic        reset_done_o, fetch_en_o;
  logic [31:0] boot_addr_o;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0, data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0, data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        eoc_o;
  logic [31:0] exit_code_o;
`ifdef MAGIA_FIXTURE_STDOUT_EN
  logic        stdout_valid_o;
  logic [7:0]  stdout_char_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  magia_tile_fixture #(.INST_WORDS(IW), .DATA_WORDS(DW), .EOC_ADDR(EOC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .pl_we_i(pl_we_i), .pl_sel_i(pl_sel_i), .pl_addr_i(pl_addr_i), .pl_wdata_i(pl_wdata_i),
    .boot_addr_i(boot_addr_i), .init_i(init_i), .run_i(run_i),
    .reset_done_o(reset_done_o), .fetch_en_o(fetch_en_o), .boot_addr_o(boot_addr_o),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .eoc_o(eoc_o),
`ifdef MAGIA_FIXTURE_STDOUT_EN
    .exit_code_o(exit_code_o),
    .stdout_valid_o(stdout_valid_o), .stdout_char_o(stdout_char_o)
`else
    .exit_code_o(exit_code_o)
`endif
  );

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } dvec_t;

  dvec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic sel, input logic [31:0] idx, input logic [31:0] wd);
    pl_we_i = 1'b1; pl_sel_i = sel; pl_addr_i = idx; pl_wdata_i = wd;
    tick();
    pl_we_i = 1'b0;
  endtask

  task automatic dacc(input string nm, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
    data_req_i = 1'b1; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wd;
    #1;
    chk({nm, ".gnt"}, 32'(data_gnt_o), 32'd1);
    tick();
    data_req_i = 1'b0; data_we_i = 1'b0;
    chk({nm, ".rvalid"}, 32'(data_rvalid_o), 32'd1);
    if (!we) chk({nm, ".rdata"}, data_rdata_o, exp);
  endtask

  task automatic iread(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    instr_req_i = 1'b1; instr_addr_i = addr;
    #1;
    chk({nm, ".gnt"}, 32'(instr_gnt_o), 32'd1);
    tick();
    instr_req_i = 1'b0;
    chk({nm, ".rvalid"}, 32'(instr_rvalid_o), 32'd1);
    chk({nm, ".rdata"}, instr_rdata_o, exp);
  endtask

  initial begin
    tbl[0] = '{"wr_w4_lo",   1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD, 32'h0};
    tbl[1] = '{"rd_w4_lo",   1'b0, 4'b0000, 32'h10, 32'h0,         32'h0000_CCDD};
    tbl[2] = '{"wr_w4_hi",   1'b1, 4'b1100, 32'h10, 32'h1122_3344, 32'h0};
    tbl[3] = '{"rd_w4_mix",  1'b0, 4'b0000, 32'h10, 32'h0,         32'h1122_CCDD};
    tbl[4] = '{"rd_w2_pl",   1'b0, 4'b0000, 32'h08, 32'h0,         32'h1111_2222};
    tbl[5] = '{"wr_w5",      1'b1, 4'b1111, 32'h14, 32'hCAFE_F00D, 32'h0};
    tbl[6] = '{"rd_oor",     1'b0, 4'b0000, 32'h40, 32'h0,         32'hDEAD_BEEF};
    tbl[7] = '{"wr_oor",     1'b1, 4'b1111, 32'h40, 32'hFFFF_FFFF, 32'h0};
    tbl[8] = '{"rd_w0_keep", 1'b0, 4'b0000, 32'h00, 32'h0,         32'h5A5A_5A5A};
    tbl[9] = '{"rd_eoc_pre", 1'b0, 4'b0000, EOC,    32'h0,         32'h0};

    // Reset phase
    repeat (5) tick();
    chk("rst.reset_done", 32'(reset_done_o), 32'd0);
    chk("rst.fetch_en",   32'(fetch_en_o),   32'd0);
    chk("rst.boot_addr",  boot_addr_o,       32'd0);
    chk("rst.eoc",        32'(eoc_o),        32'd0);
    chk("rst.exit_code",  exit_code_o,       32'd0);
    chk("rst.rvalids",    32'({instr_rvalid_o, data_rvalid_o}), 32'd0);
    rst_i = 1'b0;
    tick();
    chk("rel.reset_done", 32'(reset_done_o), 32'd1);
    chk("rel.fetch_en",   32'(fetch_en_o),   32'd0);

    // run_i in IDLE is ignored
    run_i = 1'b1; tick(); run_i = 1'b0; tick();
    chk("idle_run.fetch_en", 32'(fetch_en_o), 32'd0);

    preload(1'b0, 32'd0,  32'h0000_0013);
    preload(1'b0, 32'd1,  32'h1234_5678);
    preload(1'b0, 32'd16, 32'h0BAD_0BAD);
    preload(1'b1, 32'd0,  32'h5A5A_5A5A);
    preload(1'b1, 32'd2,  32'h1111_2222);
    preload(1'b1, 32'd4,  32'h0000_0000);

    init_i = 1'b1; boot_addr_i = 32'h80; tick(); init_i = 1'b0; boot_addr_i = 32'h44;
    chk("init.boot_addr", boot_addr_o, 32'h80);
    chk("init.fetch_en",  32'(fetch_en_o), 32'd0);
    init_i = 1'b1; tick(); init_i = 1'b0;
    chk("reinit.boot_addr", boot_addr_o, 32'h80);
    run_i = 1'b1; tick(); run_i = 1'b0;
    chk("run.fetch_en", 32'(fetch_en_o), 32'd1);

    iread("ird0", 32'h0, 32'h0000_0013);
    tick();
    chk("ird0.rvalid_drop", 32'(instr_rvalid_o), 32'd0);

    for (int i = 0; i < 10; i++)
      dacc(tbl[i].name, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    dacc("wr_stdout", 1'b1, 4'b0001, EOC + 32'd4, 32'h41, 32'h0);
    chk("stdout.eoc", 32'(eoc_o), 32'd0);

    // Preload in RUN must be ignored
    preload(1'b1, 32'd2, 32'hFFFF_FFFF);
    preload(1'b0, 32'd0, 32'h0000_0000);
    dacc("run_pl.drd", 1'b0, 4'b0, 32'h08, 32'h0, 32'h1111_2222);
    iread("run_pl.ird", 32'h0, 32'h0000_0013);
    iread("ird_oor", 32'h40, 32'hDEAD_BEEF);

    // Simultaneous instruction and data reads
    instr_req_i = 1'b1; instr_addr_i = 32'h4;
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h14;
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b0;
    chk("dual.irvalid", 32'(instr_rvalid_o), 32'd1);
    chk("dual.irdata",  instr_rdata_o, 32'h1234_5678);
    chk("dual.drvalid", 32'(data_rvalid_o), 32'd1);
    chk("dual.drdata",  data_rdata_o, 32'hCAFE_F00D);

    // EOC write ends the run
    dacc("eoc_wr", 1'b1, 4'b1111, EOC, 32'h0, 32'h0);
    chk("eoc.eoc",      32'(eoc_o), 32'd1);
    chk("eoc.exit",     exit_code_o, 32'h0);
    chk("eoc.fetch_en", 32'(fetch_en_o), 32'd0);
    dacc("done_wr", 1'b1, 4'b1111, EOC, 32'h5, 32'h0);
    chk("done.exit", exit_code_o, 32'h0);
    chk("done.eoc",  32'(eoc_o), 32'd1);

    // Reset from DONE, memory retained, second run with nonzero exit code
    rst_i = 1'b1; tick();
    chk("rst2.eoc",        32'(eoc_o), 32'd0);
    chk("rst2.reset_done", 32'(reset_done_o), 32'd0);
    rst_i = 1'b0; tick();
    dacc("rst2.keep", 1'b0, 4'b0, 32'h14, 32'h0, 32'hCAFE_F00D);
    init_i = 1'b1; boot_addr_i = 32'h200; tick(); init_i = 1'b0;
    run_i = 1'b1; tick(); run_i = 1'b0;
    chk("run2.boot",     boot_addr_o, 32'h200);
    chk("run2.fetch_en", 32'(fetch_en_o), 32'd1);
    dacc("eoc2_wr", 1'b1, 4'b1111, EOC, 32'h2A, 32'h0);
    chk("eoc2.exit",     exit_code_o, 32'h2A);
    chk("eoc2.fetch_en", 32'(fetch_en_o), 32'd0);
    dacc("eoc2_rd", 1'b0, 4'b0, EOC, 32'h0, 32'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
